// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use bubble, multiply/divide freeze, branch flush,
// and a saturating count of cycles in which the PC was held.
module hazard_stall_controller #(
   parameter int REG_ADDR_W = 5,
   parameter int MD_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] IF_ID_RegRs,
   input  logic [REG_ADDR_W-1:0] IF_ID_RegRt,
   input  logic                  IF_ID_UsesRt,
   input  logic [REG_ADDR_W-1:0] ID_EX_RegRt,
   input  logic                  ID_EX_MemRead,
   input  logic                  ID_EX_MulDiv,
   input  logic                  EX_BranchTaken,
   output logic                  PC_Write,
   output logic                  IF_ID_Write,
   output logic                  ID_EX_Write,
   output logic                  ID_EX_Bubble,
   output logic                  EX_MEM_Bubble,
   output logic                  IF_ID_Flush,
   output logic                  ID_EX_Flush,
   output logic                  MD_Start,
   output logic                  MD_Busy,
   output logic [15:0]           StallCycles
);

   typedef enum logic {RUN, MD_WAIT} state_t;

   localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

   state_t      state_q, state_d;
   logic [7:0]  md_cnt_q, md_cnt_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic        load_use;

   // A zero destination never creates a dependency (r0 is hardwired).
   assign load_use = ID_EX_MemRead && (ID_EX_RegRt != '0) &&
                     ((ID_EX_RegRt == IF_ID_RegRs) ||
                      (IF_ID_UsesRt && (ID_EX_RegRt == IF_ID_RegRt)));

   always_comb begin
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Write   = 1'b1;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Bubble = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      MD_Start      = 1'b0;
      MD_Busy       = 1'b0;
      state_d       = state_q;
      md_cnt_d      = md_cnt_q;

      if (!reset) begin
         case (state_q)
            RUN: begin
               if (EX_BranchTaken) begin
                  IF_ID_Flush = 1'b1;
                  ID_EX_Flush = 1'b1;
               end else if (ID_EX_MulDiv) begin
                  MD_Start      = 1'b1;
                  PC_Write      = 1'b0;
                  IF_ID_Write   = 1'b0;
                  ID_EX_Write   = 1'b0;
                  EX_MEM_Bubble = 1'b1;
                  state_d       = MD_WAIT;
                  md_cnt_d      = MD_LOAD;
               end else if (load_use) begin
                  PC_Write     = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
               end
            end
            MD_WAIT: begin
               MD_Busy = 1'b1;
               // On the final count the freeze drops so EX/MEM captures the result;
               // the still-asserted ID_EX_MulDiv is not looked at in this state.
               if (md_cnt_q != 8'd0) begin
                  PC_Write      = 1'b0;
                  IF_ID_Write   = 1'b0;
                  ID_EX_Write   = 1'b0;
                  EX_MEM_Bubble = 1'b1;
                  md_cnt_d      = md_cnt_q - 8'd1;
               end else begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!PC_Write && (stall_cycles_q != 16'hFFFF))
         stall_cycles_d = stall_cycles_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         md_cnt_q       <= 8'd0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         md_cnt_q       <= md_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign StallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: load-use, rt gating, multiply/divide
// timeline, branch priority, reset abort and counter saturation.
module tb_hazard_stall_controller;

   localparam int REG_ADDR_W = 5;
   localparam int MD_LATENCY = 4;

   // Packed control view: {PC_W, IFID_W, IDEX_W, IDEX_Bub, EXMEM_Bub, IFID_Fl, IDEX_Fl, MD_Start, MD_Busy}
   localparam logic [8:0] C_DEF     = 9'b111_00_00_0_0;
   localparam logic [8:0] C_LU      = 9'b001_10_00_0_0;
   localparam logic [8:0] C_START   = 9'b000_01_00_1_0;
   localparam logic [8:0] C_FREEZE  = 9'b000_01_00_0_1;
   localparam logic [8:0] C_RELEASE = 9'b111_00_00_0_1;
   localparam logic [8:0] C_BRANCH  = 9'b111_00_11_0_0;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [REG_ADDR_W-1:0] IF_ID_RegRs, IF_ID_RegRt, ID_EX_RegRt;
   logic                  IF_ID_UsesRt, ID_EX_MemRead, ID_EX_MulDiv, EX_BranchTaken;
   logic                  PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble;
   logic                  IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy;
   logic [15:0]           StallCycles;
   logic [8:0]            ctl;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hazard_stall_controller #(.REG_ADDR_W(REG_ADDR_W), .MD_LATENCY(MD_LATENCY)) dut (
      .clk(clk), .reset(reset),
      .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt), .IF_ID_UsesRt(IF_ID_UsesRt),
      .ID_EX_RegRt(ID_EX_RegRt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MulDiv(ID_EX_MulDiv),
      .EX_BranchTaken(EX_BranchTaken),
      .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
      .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Bubble(EX_MEM_Bubble),
      .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
      .MD_Start(MD_Start), .MD_Busy(MD_Busy), .StallCycles(StallCycles)
   );

   assign ctl = {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble,
                 IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy};

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic [4:0] exrt, input logic memrd, input logic md,
                         input logic br);
      IF_ID_RegRs    = rs;
      IF_ID_RegRt    = rt;
      IF_ID_UsesRt   = uses;
      ID_EX_RegRt    = exrt;
      ID_EX_MemRead  = memrd;
      ID_EX_MulDiv   = md;
      EX_BranchTaken = br;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      next_cycle();
      check("rst_ctl_loaduse_inputs", 16'(ctl), 16'(C_DEF));
      ID_EX_MulDiv = 1'b1;
      #1 check("rst_ctl_md_inputs", 16'(ctl), 16'(C_DEF));
      next_cycle();
      reset = 1'b0;
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("rst_stall_cnt", StallCycles, 16'd0);
      check("rst_idle_ctl", 16'(ctl), 16'(C_DEF));

      // Load-use on rs
      next_cycle();
      set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      #1 check("lu_rs_ctl", 16'(ctl), 16'(C_LU));
      next_cycle();
      set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
      #1 check("lu_rs_after_ctl", 16'(ctl), 16'(C_DEF));
      check("lu_rs_cnt", StallCycles, 16'd1);
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      #1 check("lu_r0_ctl", 16'(ctl), 16'(C_DEF));
      next_cycle();
      check("lu_r0_cnt", StallCycles, 16'd1);

      // rt gating by IF_ID_UsesRt
      set_in(5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      #1 check("rt_unused_ctl", 16'(ctl), 16'(C_DEF));
      IF_ID_UsesRt = 1'b1;
      #1 check("rt_used_ctl", 16'(ctl), 16'(C_LU));
      next_cycle();
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("rt_used_cnt", StallCycles, 16'd2);

      // Multiply/divide with ID_EX_MulDiv held through the release cycle
      next_cycle();
      ID_EX_MulDiv = 1'b1;
      #1 check("md_c0", 16'(ctl), 16'(C_START));
      next_cycle();
      check("md_c1", 16'(ctl), 16'(C_FREEZE));
      next_cycle();
      check("md_c2", 16'(ctl), 16'(C_FREEZE));
      next_cycle();
      check("md_c3", 16'(ctl), 16'(C_FREEZE));
      next_cycle();
      check("md_c4_release", 16'(ctl), 16'(C_RELEASE));
      check("md_cnt", StallCycles, 16'd6);
      next_cycle();
      ID_EX_MulDiv = 1'b0;
      #1 check("md_after_ctl", 16'(ctl), 16'(C_DEF));
      check("md_after_cnt", StallCycles, 16'd6);

      // Branch beats load-use and multiply/divide
      set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
      #1 check("br_lu_ctl", 16'(ctl), 16'(C_BRANCH));
      next_cycle();
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      #1 check("br_md_ctl", 16'(ctl), 16'(C_BRANCH));
      check("br_cnt", StallCycles, 16'd6);
      next_cycle();
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("br_md_no_wait", 16'(ctl), 16'(C_DEF));

      // Reset while in MD_WAIT with md_cnt=2
      next_cycle();
      ID_EX_MulDiv = 1'b1;
      #1 check("rmd_c0", 16'(ctl), 16'(C_START));
      next_cycle();
      check("rmd_c1", 16'(ctl), 16'(C_FREEZE));
      next_cycle();
      check("rmd_c2", 16'(ctl), 16'(C_FREEZE));
      check("rmd_c2_cnt", StallCycles, 16'd8);
      reset = 1'b1;
      #1 check("rmd_in_reset", 16'(ctl), 16'(C_DEF));
      next_cycle();
      reset = 1'b0;
      ID_EX_MulDiv = 1'b0;
      #1 check("rmd_after_ctl", 16'(ctl), 16'(C_DEF));
      check("rmd_after_cnt", StallCycles, 16'd0);
      next_cycle();
      check("rmd_stays_idle", 16'(ctl), 16'(C_DEF));

      // Saturation: hold a load-use hazard for 65,540 cycles
      set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      #1 check("sat_ctl", 16'(ctl), 16'(C_LU));
      repeat (65535) next_cycle();
      check("sat_at_max", StallCycles, 16'hFFFF);
      repeat (5) next_cycle();
      check("sat_hold", StallCycles, 16'hFFFF);
      check("sat_ctl_still", 16'(ctl), 16'(C_LU));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
